// File: rtl/project2_nios2_qsys_0_oci_trace_pkg.sv
// Shared types for the OCI trace monitor: FSM state encoding and snapshot width helper.
package project2_nios2_qsys_0_oci_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_ENDED   = 2'd3
    } trace_state_e;

    function automatic int snap_width(input int cnt_w, input int buf_w);
        return cnt_w + buf_w;
    endfunction

endpackage

// File: rtl/project2_nios2_qsys_0_oci_trace_fifo.sv
// Synchronous snapshot FIFO with a registered read port and level-derived full/empty.
module project2_nios2_qsys_0_oci_trace_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is only legal when a pop frees the slot it reuses.
    always_comb begin
        full       = (level_q == LW'(DEPTH));
        empty      = (level_q == '0);
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = do_pop;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = mem[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign level    = level_q;

endmodule

// File: rtl/project2_nios2_qsys_0_oci_trace_monitor.sv
// Captures {dct_count, dct_buffer} snapshots whenever the DCT count changes and
// buffers them for readout, with end-of-test freeze and drop/underflow accounting.
module project2_nios2_qsys_0_oci_trace_monitor
    import project2_nios2_qsys_0_oci_trace_pkg::*;
#(
    parameter int BUF_W       = 30,
    parameter int CNT_W       = 4,
    parameter int DEPTH       = 16,
    parameter int STOP_ON_END = 1,
    localparam int SNAP_W     = snap_width(CNT_W, BUF_W),
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BUF_W-1:0]  dct_buffer,
    input  logic [CNT_W-1:0]  dct_count,
    input  logic              test_ending,
    input  logic              test_has_ended,
    input  logic              rd_req,
    output logic [SNAP_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [LW-1:0]     level,
    output logic [31:0]       frame_count,
    output logic [15:0]       drop_count,
    output logic              overflow,
    output logic              underflow,
    output logic              done,
    output logic [1:0]        state
);

    trace_state_e     state_q, state_d;
    logic [CNT_W-1:0] prev_count_q;
    logic [31:0]      frame_count_q, frame_count_d;
    logic [15:0]      drop_count_q, drop_count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             change, capture, pop_ok, drop, accept;
    logic             fifo_full, fifo_empty;

    // Change events are only captured while IDLE/CAPTURE; later they are silently ignored.
    always_comb begin
        change        = (dct_count != prev_count_q);
        capture       = change && (state_q == ST_IDLE || state_q == ST_CAPTURE);
        pop_ok        = rd_req && !fifo_empty;
        drop          = capture && fifo_full && !pop_ok;
        accept        = capture && !drop;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q | drop;
        underflow_d   = underflow_q | (rd_req && fifo_empty);
        state_d       = state_q;
        if (accept && frame_count_q != '1) begin
            frame_count_d = frame_count_q + 32'd1;
        end
        if (drop && drop_count_q != '1) begin
            drop_count_d = drop_count_q + 16'd1;
        end
        case (state_q)
            ST_IDLE:    if (change) state_d = ST_CAPTURE;
            ST_CAPTURE: if (test_ending && STOP_ON_END != 0) state_d = ST_DRAIN;
            default:    state_d = state_q;
        endcase
        if (test_has_ended) begin
            state_d = ST_ENDED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            prev_count_q  <= dct_count;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_count_q  <= dct_count;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    project2_nios2_qsys_0_oci_trace_fifo #(
        .WIDTH(SNAP_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .pop     (rd_req),
        .wr_data ({dct_count, dct_buffer}),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign done        = (state_q == ST_ENDED);
    assign state       = state_q;

endmodule

// File: tb/tb_project2_nios2_qsys_0_oci_trace_monitor.sv
// Randomized self-checking bench for the OCI trace monitor against a queue-based reference model.
module tb_project2_nios2_qsys_0_oci_trace_monitor;

    localparam int BUF_W  = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int SNAP_W = CNT_W + BUF_W;
    localparam int LW     = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              test_ending;
    logic              test_has_ended;
    logic              rd_req;
    logic [SNAP_W-1:0] rd_data;
    logic              rd_valid;
    logic [LW-1:0]     level;
    logic [31:0]       frame_count;
    logic [15:0]       drop_count;
    logic              overflow;
    logic              underflow;
    logic              done;
    logic [1:0]        state;

    int testCount = 0;
    int failCount = 0;

    // Reference model: IDLE=0, CAPTURE=1, DRAIN=2, ENDED=3
    int                mState;
    logic [CNT_W-1:0]  mPrev;
    logic [SNAP_W-1:0] mq[$];
    logic [31:0]       mFrame;
    logic [15:0]       mDrop;
    logic              mOvf, mUnf, mValid;
    logic [SNAP_W-1:0] mData;
    logic [CNT_W-1:0]  curCnt;

    project2_nios2_qsys_0_oci_trace_monitor #(
        .BUF_W(BUF_W),
        .CNT_W(CNT_W),
        .DEPTH(DEPTH),
        .STOP_ON_END(1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dct_buffer    (dct_buffer),
        .dct_count     (dct_count),
        .test_ending   (test_ending),
        .test_has_ended(test_has_ended),
        .rd_req        (rd_req),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .level         (level),
        .frame_count   (frame_count),
        .drop_count    (drop_count),
        .overflow      (overflow),
        .underflow     (underflow),
        .done          (done),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep();
        bit change, capture, isEmpty, isFull, pop;
        if (reset) begin
            mState = 0;
            mq.delete();
            mFrame = 0;
            mDrop  = 0;
            mOvf   = 0;
            mUnf   = 0;
            mValid = 0;
            mData  = '0;
            mPrev  = dct_count;
        end else begin
            change  = (dct_count != mPrev);
            mPrev   = dct_count;
            capture = change && (mState == 0 || mState == 1);
            isEmpty = (mq.size() == 0);
            isFull  = (mq.size() == DEPTH);
            pop     = rd_req && !isEmpty;
            mValid  = pop;
            if (pop) mData = mq.pop_front();
            if (rd_req && isEmpty) mUnf = 1;
            if (capture) begin
                if (!isFull || pop) begin
                    mq.push_back({dct_count, dct_buffer});
                    if (mFrame != 32'hFFFF_FFFF) mFrame++;
                end else begin
                    if (mDrop != 16'hFFFF) mDrop++;
                    mOvf = 1;
                end
            end
            if (test_has_ended) mState = 3;
            else if (mState == 0 && change) mState = 1;
            else if (mState == 1 && test_ending) mState = 2;
        end
    endtask

    task automatic compareAll();
        checkOutput("state",       64'(state),       64'(mState));
        checkOutput("level",       64'(level),       64'(mq.size()));
        checkOutput("frame_count", 64'(frame_count), 64'(mFrame));
        checkOutput("drop_count",  64'(drop_count),  64'(mDrop));
        checkOutput("overflow",    64'(overflow),    64'(mOvf));
        checkOutput("underflow",   64'(underflow),   64'(mUnf));
        checkOutput("done",        64'(done),        64'(mState == 3));
        checkOutput("rd_valid",    64'(rd_valid),    64'(mValid));
        checkOutput("rd_data",     64'(rd_data),     64'(mData));
    endtask

    task automatic applyStimulus(input logic r, input logic [CNT_W-1:0] c, input logic [BUF_W-1:0] b,
                                 input logic te, input logic the, input logic rd);
        reset          = r;
        dct_count      = c;
        dct_buffer     = b;
        test_ending    = te;
        test_has_ended = the;
        rd_req         = rd;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic doReset();
        curCnt = '0;
        applyStimulus(1, curCnt, '0, 0, 0, 0);
        applyStimulus(1, curCnt, '0, 0, 0, 0);
    endtask

    task automatic nextCount(input logic [BUF_W-1:0] b, input logic rd);
        curCnt = curCnt + CNT_W'(1);
        applyStimulus(0, curCnt, b, 0, 0, rd);
    endtask

    task automatic idleCycle(input logic te, input logic the, input logic rd);
        applyStimulus(0, curCnt, '0, te, the, rd);
    endtask

    initial begin
        logic [CNT_W-1:0] rc;
        doReset();
        checkOutput("reset_state", 64'(state), 64'd0);
        checkOutput("reset_level", 64'(level), 64'd0);
        idleCycle(0, 0, 0);
        checkOutput("no_event_after_reset", 64'(state), 64'd0);

        nextCount(30'h1, 0);
        nextCount(30'h2, 0);
        checkOutput("basic_state", 64'(state), 64'd1);
        checkOutput("basic_level", 64'(level), 64'd2);
        checkOutput("basic_frames", 64'(frame_count), 64'd2);
        idleCycle(0, 0, 1);
        checkOutput("basic_rd0", 64'(rd_data), 64'({4'd1, 30'h1}));
        idleCycle(0, 0, 1);
        checkOutput("basic_rd1", 64'(rd_data), 64'({4'd2, 30'h2}));
        idleCycle(0, 0, 0);
        checkOutput("rd_valid_pulse", 64'(rd_valid), 64'd0);
        checkOutput("rd_data_hold", 64'(rd_data), 64'({4'd2, 30'h2}));

        doReset();
        for (int i = 1; i <= 18; i++) nextCount(BUF_W'(i), 0);
        checkOutput("full_level", 64'(level), 64'd16);
        checkOutput("full_frames", 64'(frame_count), 64'd16);
        checkOutput("full_drops", 64'(drop_count), 64'd2);
        checkOutput("full_overflow", 64'(overflow), 64'd1);
        nextCount(30'h3FF, 1);
        checkOutput("fullrw_level", 64'(level), 64'd16);
        checkOutput("fullrw_drops", 64'(drop_count), 64'd2);
        checkOutput("fullrw_oldest", 64'(rd_data), 64'({4'd1, 30'h1}));

        idleCycle(1, 0, 0);
        for (int i = 0; i < 3; i++) nextCount(BUF_W'(i), 0);
        checkOutput("drain_state", 64'(state), 64'd2);
        checkOutput("drain_frames", 64'(frame_count), 64'd17);
        idleCycle(0, 1, 0);
        checkOutput("ended_done", 64'(done), 64'd1);
        checkOutput("ended_state", 64'(state), 64'd3);

        doReset();
        idleCycle(0, 0, 1);
        checkOutput("underflow_flag", 64'(underflow), 64'd1);
        checkOutput("underflow_valid", 64'(rd_valid), 64'd0);
        for (int i = 0; i < 5; i++) nextCount(BUF_W'(i + 7), 0);
        checkOutput("mid_level", 64'(level), 64'd5);
        applyStimulus(1, curCnt, '0, 0, 0, 0);
        checkOutput("midrst_level", 64'(level), 64'd0);
        checkOutput("midrst_state", 64'(state), 64'd0);
        checkOutput("midrst_underflow", 64'(underflow), 64'd0);

        for (int i = 0; i < 2000; i++) begin
            rc = ($urandom_range(1) == 0) ? CNT_W'($urandom) : curCnt;
            curCnt = rc;
            applyStimulus(($urandom_range(99) == 0), rc, BUF_W'($urandom),
                          ($urandom_range(59) == 0), ($urandom_range(199) == 0),
                          ($urandom_range(3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/project2_nios2_qsys_0_oci_trace_monitor.md
PROJECT2_NIOS2_QSYS_0_OCI_TRACE_MONITOR -- requirements
Module: project2_nios2_qsys_0_oci_trace_monitor

Interface
REQ-001 Parameter BUF_W, default 30, width of the debug capture trace (DCT) buffer word.
REQ-002 Parameter CNT_W, default 4, width of the DCT count.
REQ-003 Parameter DEPTH, default 16, number of snapshot entries, power of two, at least 2.
REQ-004 Parameter STOP_ON_END, default 1; when 1, test_ending freezes capture, when 0 capture continues until test_has_ended.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 dct_buffer  in  BUF_W  DCT buffer contents from the OCI.
REQ-008 dct_count  in  CNT_W  DCT entry count from the OCI.
REQ-009 test_ending  in  1  simulation end requested.
REQ-010 test_has_ended  in  1  simulation end reached.
REQ-011 rd_req  in  1  pop one snapshot.
REQ-012 rd_data  out  CNT_W+BUF_W  popped snapshot {count, buffer}.
REQ-013 rd_valid  out  1  rd_data valid, one-cycle pulse.
REQ-014 level  out  clog2(DEPTH)+1  entries held.
REQ-015 frame_count  out  32  accepted snapshots, saturating.
REQ-016 drop_count  out  16  snapshots dropped while full, saturating.
REQ-017 overflow  out  1  sticky, set on the first drop.
REQ-018 underflow  out  1  sticky, set when rd_req arrives while empty.
REQ-019 done  out  1  asserted in state ENDED.
REQ-020 state  out  2  current FSM state: IDLE=0, CAPTURE=1, DRAIN=2, ENDED=3.

Function
REQ-021 The block shall register dct_count each cycle into prev_count; a change event is dct_count != prev_count.
REQ-022 IDLE shall go to CAPTURE on the first change event; that event shall itself be captured.
REQ-023 CAPTURE shall push {dct_count, dct_buffer}, sampled on the event cycle, into the FIFO on every change event.
REQ-024 CAPTURE shall go to DRAIN on test_ending when STOP_ON_END=1; when STOP_ON_END=0, test_ending shall be ignored.
REQ-025 From any state, test_has_ended shall force ENDED, and ENDED shall persist until reset.
REQ-026 In DRAIN and ENDED, change events shall be discarded and not counted as drops.
REQ-027 A push shall occur only when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Push and pop in the same cycle: both take effect and level is unchanged.
REQ-028 A push when full without a pop shall drop the snapshot, increment drop_count, set overflow, and leave the FIFO and frame_count unchanged.
REQ-029 A pop shall present the oldest entry on rd_data with rd_valid asserted in the cycle after rd_req, in every state.
REQ-030 rd_req while empty shall set underflow, leave rd_valid at 0, and leave pointers unchanged.
  - A push in the same cycle as an empty-read is not readable in that cycle.
REQ-031 Read and write pointers shall be clog2(DEPTH) bits and wrap modulo DEPTH; full and empty shall be derived from level.
REQ-032 frame_count and drop_count shall saturate at all-ones.
REQ-033 rd_data shall hold its last value when rd_valid is 0.

Reset
REQ-034 Reset shall set state=IDLE, level=0, both pointers=0, frame_count=0, drop_count=0, overflow=0, underflow=0, rd_valid=0, done=0, rd_data=0, prev_count=dct_count.
  - Because prev_count loads dct_count, no change event occurs in the cycle after reset.
REQ-035 Reset asserted mid-operation shall discard all stored entries within one cycle, and reset shall have priority over every other input.

Structure
REQ-036 A shared package shall hold the state enum, the state encoding and the snapshot-width function CNT_W+BUF_W.
REQ-037 Storage shall be one sub-module, project2_nios2_qsys_0_oci_trace_fifo, a synchronous FIFO with a registered read and parameters WIDTH and DEPTH.

Verification
REQ-038 Reset, then dct_count 0->1->2 with dct_buffer 0x1, 0x2 -> state=CAPTURE, level=2, frame_count=2; two rd_req -> rd_data {1,0x1} then {2,0x2}.
REQ-039 DEPTH=16: 18 count changes with no reads -> level=16, frame_count=16, drop_count=2, overflow=1.
REQ-040 Full FIFO, change event together with rd_req -> level stays 16, drop_count unchanged, rd_data = oldest entry.
REQ-041 STOP_ON_END=1: test_ending, then 3 count changes -> state=DRAIN, frame_count unchanged; then test_has_ended -> done=1, state=3.
REQ-042 rd_req while empty -> underflow=1, rd_valid=0; then reset mid-CAPTURE with level=5 -> level=0, state=IDLE, underflow=0 the next cycle.
